// File: rtl/vex_pkg.sv
// Shared types and helpers for the vector lane execution stage.
//
// Contents:
//   vex_op_e    - issue opcodes (ADD, SUB, AND, OR, XOR, MUL); other codes behave as ADD
//   sew_e       - element width select (8/16/32/64 bits)
//   vex_meta_t  - per-op side information carried alongside a result
//   elem_op     - element-wise arithmetic, modulo 2^SEW, no carry across elements
//   merge_mask  - per-element select between a new result and the old destination
//
// VEX_DW and VEX_DEST_W size the meta struct.
// vex_pipe's DATA_WIDTH and DEST_W parameters must match VEX_DW and VEX_DEST_W.
package vex_pkg;

  localparam int VEX_DW     = 64;
  localparam int VEX_MW     = VEX_DW / 8;
  localparam int VEX_MIW    = $clog2(VEX_MW);
  localparam int VEX_DEST_W = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_MUL = 4'd5
  } vex_op_e;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  typedef struct packed {
    logic                  valid;
    logic [VEX_DEST_W-1:0] dest;
    sew_e                  sew;
    logic                  masked;
    logic [VEX_MW-1:0]     mask;
    logic [VEX_DW-1:0]     vd_old;
  } vex_meta_t;

  // Each element is isolated into a 64-bit slot, operated on, and trimmed back to SEW bits.
  // This keeps carries, borrows and high product bits from leaking into the neighbouring element.
  function automatic logic [VEX_DW-1:0] elem_op(input vex_op_e op, input sew_e sew,
                                                input logic [VEX_DW-1:0] a,
                                                input logic [VEX_DW-1:0] b);
    logic [VEX_DW-1:0] r;
    logic [63:0]       x;
    logic [63:0]       y;
    logic [63:0]       z;
    logic [63:0]       emask;
    int                ew;
    ew    = 8 << int'(sew);
    emask = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
    r     = '0;
    for (int i = 0; i < VEX_DW / 8; i++) begin
      if (i < VEX_DW / ew) begin
        x = 64'(a >> (i * ew)) & emask;
        y = 64'(b >> (i * ew)) & emask;
        case (op)
          OP_SUB:  z = x - y;
          OP_AND:  z = x & y;
          OP_OR:   z = x | y;
          OP_XOR:  z = x ^ y;
          OP_MUL:  z = x * y;
          default: z = x + y;
        endcase
        z = z & emask;
        r = r | (VEX_DW'(z) << (i * ew));
      end
    end
    return r;
  endfunction

  // Bit b belongs to element b / SEW.
  // Mask bits past the last element of the current SEW therefore never get selected.
  function automatic logic [VEX_DW-1:0] merge_mask(input logic [VEX_DW-1:0] result,
                                                   input logic [VEX_DW-1:0] vd_old,
                                                   input logic [VEX_MW-1:0] mask,
                                                   input sew_e              sew);
    logic [VEX_DW-1:0]  m;
    logic [VEX_MIW-1:0] idx;
    m = '0;
    for (int b = 0; b < VEX_DW; b++) begin
      idx  = VEX_MIW'(b >> (3 + int'(sew)));
      m[b] = mask[idx] ? result[b] : vd_old[b];
    end
    return m;
  endfunction

endpackage

// File: rtl/vex_pipe_if.sv
// Issue and writeback bus of the vector lane execution stage.
//
// Issue side:
//   in_valid/in_ready handshake, plus in_op, in_sew, in_vs1, in_vs2, in_vd_old,
//   in_masked, in_mask and in_dest.
// Writeback side:
//   wb_valid, wb_dest, wb_sew and wb_result.
//
// Modports:
//   master - the register-read stage; drives the issue side and observes writeback.
//   slave  - vex_pipe.
interface vex_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int OP_W       = 4,
  parameter int DEST_W     = 5
);

  logic                    in_valid;
  logic                    in_ready;
  logic [OP_W-1:0]         in_op;
  logic [1:0]              in_sew;
  logic [DATA_WIDTH-1:0]   in_vs1;
  logic [DATA_WIDTH-1:0]   in_vs2;
  logic [DATA_WIDTH-1:0]   in_vd_old;
  logic                    in_masked;
  logic [DATA_WIDTH/8-1:0] in_mask;
  logic [DEST_W-1:0]       in_dest;

  logic                    wb_valid;
  logic [DEST_W-1:0]       wb_dest;
  logic [1:0]              wb_sew;
  logic [DATA_WIDTH-1:0]   wb_result;

  modport master (
    output in_valid, in_op, in_sew, in_vs1, in_vs2, in_vd_old, in_masked, in_mask, in_dest,
    input  in_ready, wb_valid, wb_dest, wb_sew, wb_result
  );

  modport slave (
    input  in_valid, in_op, in_sew, in_vs1, in_vs2, in_vd_old, in_masked, in_mask, in_dest,
    output in_ready, wb_valid, wb_dest, wb_sew, wb_result
  );

endinterface

// File: rtl/vex_mul_pipe.sv
// Multiply delay line of the vector lane execution stage.
//
// The product is formed at issue and carried with its meta here.
// The shared writeback register in vex_pipe acts as the final stage of the multiply.
// This module therefore holds MUL_LATENCY-1 stages, numbered 0 .. MUL_LATENCY-2.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset (clears every stage)
//   stall       - freezes every stage
//   in_meta     - meta of the op entering stage 0 (valid=0 for a bubble)
//   in_product  - element-wise low-half product
//   out_meta    - meta of the last stage
//   out_product - product of the last stage
//   hazard      - last-stage valid; this op takes the writeback register on the next edge
module vex_mul_pipe
  import vex_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  vex_meta_t             in_meta,
  input  logic [DATA_WIDTH-1:0] in_product,
  output vex_meta_t             out_meta,
  output logic [DATA_WIDTH-1:0] out_product,
  output logic                  hazard
);

  localparam int DEPTH = MUL_LATENCY - 1;

  vex_meta_t             meta_q [DEPTH];
  logic [DATA_WIDTH-1:0] prod_q [DEPTH];

  // Shift register of meta and product; frozen on stall, emptied on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i] <= '0;
        prod_q[i] <= '0;
      end
    end else if (!stall) begin
      meta_q[0] <= in_meta;
      prod_q[0] <= in_product;
      for (int i = 1; i < DEPTH; i++) begin
        meta_q[i] <= meta_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign out_meta    = meta_q[DEPTH-1];
  assign out_product = prod_q[DEPTH-1];
  assign hazard      = meta_q[DEPTH-1].valid;

endmodule

// File: rtl/vex_pipe.sv
// Vector lane execution stage.
// It sits between vector register read and lane writeback.
//
// Datapaths:
//   Single-cycle ALU path  - ADD/SUB/AND/OR/XOR.
//   Multiply pipeline      - MUL_LATENCY-deep.
//   Both paths share one writeback register.
//   A non-MUL op is refused while a MUL is about to claim that register,
//   so writeback is never contended.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   io               - vex_pipe_if.slave issue/writeback bus
//   stall            - freezes the whole pipeline, including writeback
//   load_wait_in/out - load-wait side-band, one-cycle delay, unaffected by stall
//   load_dest_in/out - load destination side-band, one-cycle delay, unaffected by stall
//   perf_issued      - only with VEX_PIPE_PERF_EN: saturating count of accepted ops
//   perf_collide     - only with VEX_PIPE_PERF_EN: saturating count of cycles an op was
//                      refused for collision
//
// Build option: define VEX_PIPE_PERF_EN to add the perf counters and their ports.
module vex_pipe
  import vex_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int MUL_LATENCY = 3,
  parameter int OP_W        = 4,
  parameter int DEST_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  vex_pipe_if.slave        io,
  input  logic             stall,
  input  logic             load_wait_in,
  input  logic [4:0]       load_dest_in,
  output logic             load_wait_out,
  output logic [4:0]       load_dest_out
`ifdef VEX_PIPE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_collide
`endif
);

  logic [OP_W-1:0]       op_raw;
  vex_op_e               op;
  sew_e                  sew;
  logic                  is_mul;
  logic                  hazard;
  logic                  collide;
  logic                  accept;
  logic [DATA_WIDTH-1:0] raw_res;
  logic [DATA_WIDTH-1:0] alu_res;
  vex_meta_t             issue_meta;
  vex_meta_t             mul_meta;
  logic [DATA_WIDTH-1:0] mul_prod;
  logic [DATA_WIDTH-1:0] mul_res;

  logic                  wb_valid_q;
  logic [DEST_W-1:0]     wb_dest_q;
  logic [1:0]            wb_sew_q;
  logic [DATA_WIDTH-1:0] wb_result_q;

  assign op_raw = io.in_op;
  assign op     = vex_op_e'(op_raw);
  assign sew    = sew_e'(io.in_sew);
  assign is_mul = (op == OP_MUL);

  // A MUL never waits. It always lands exactly MUL_LATENCY cycles out, on a slot that no
  // one-cycle op can be holding. Only a non-MUL op can clash with a MUL due next cycle.
  assign collide     = hazard & !is_mul;
  assign io.in_ready = !rst & !stall & !collide;
  assign accept      = io.in_valid & io.in_ready;

  // One element-wise unit serves both paths. Its result goes to the writeback register
  // for ALU ops, or into the multiply delay line for MUL.
  assign raw_res = elem_op(op, sew, io.in_vs1, io.in_vs2);
  assign alu_res = io.in_masked ? merge_mask(raw_res, io.in_vd_old, io.in_mask, sew) : raw_res;

  // Meta for an accepted MUL; a bubble (valid=0) otherwise.
  always_comb begin
    issue_meta        = '0;
    issue_meta.valid  = accept & is_mul;
    issue_meta.dest   = io.in_dest;
    issue_meta.sew    = sew;
    issue_meta.masked = io.in_masked;
    issue_meta.mask   = io.in_mask;
    issue_meta.vd_old = io.in_vd_old;
  end

  vex_mul_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .in_meta     (issue_meta),
    .in_product  (raw_res),
    .out_meta    (mul_meta),
    .out_product (mul_prod),
    .hazard      (hazard)
  );

  assign mul_res = mul_meta.masked ?
                   merge_mask(mul_prod, mul_meta.vd_old, mul_meta.mask, mul_meta.sew) : mul_prod;

  // Shared writeback register.
  // A retiring MUL and a newly accepted ALU op are mutually exclusive through collide.
  // While stalled, the held result stays put and is shown once stall drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= '0;
      wb_sew_q    <= '0;
      wb_result_q <= '0;
    end else if (!stall) begin
      wb_valid_q <= 1'b0;
      if (mul_meta.valid) begin
        wb_valid_q  <= 1'b1;
        wb_dest_q   <= mul_meta.dest;
        wb_sew_q    <= mul_meta.sew;
        wb_result_q <= mul_res;
      end else if (accept && !is_mul) begin
        wb_valid_q  <= 1'b1;
        wb_dest_q   <= io.in_dest;
        wb_sew_q    <= io.in_sew;
        wb_result_q <= alu_res;
      end
    end
  end

  assign io.wb_valid  = wb_valid_q & !stall;
  assign io.wb_dest   = wb_dest_q;
  assign io.wb_sew    = wb_sew_q;
  assign io.wb_result = wb_result_q;

  // Load side-band delay; runs through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_wait_out <= 1'b0;
      load_dest_out <= '0;
    end else begin
      load_wait_out <= load_wait_in;
      load_dest_out <= load_dest_in;
    end
  end

`ifdef VEX_PIPE_PERF_EN
  // Saturating event counters for accepted ops and collision-refused cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued  <= '0;
      perf_collide <= '0;
    end else begin
      if (accept && (perf_issued != '1)) perf_issued <= perf_issued + 32'd1;
      if (io.in_valid && collide && !stall && (perf_collide != '1))
        perf_collide <= perf_collide + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vex_pipe.sv
// Self-checking bench for vex_pipe (DATA_WIDTH=64, MUL_LATENCY=3).
//
// A reference model holds the ops in flight.
// Each op carries the number of unstalled edges left before it appears on writeback.
// Expected values are computed element by element from the op rules.
module tb_vex_pipe;
  import vex_pkg::*;

  localparam int DW = 64;
  localparam int L  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       load_wait_in;
  logic [4:0] load_dest_in;
  logic       load_wait_out;
  logic [4:0] load_dest_out;
`ifdef VEX_PIPE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_collide;
`endif

  vex_pipe_if #(.DATA_WIDTH(DW), .OP_W(4), .DEST_W(5)) bus ();

  vex_pipe #(.DATA_WIDTH(DW), .MUL_LATENCY(L), .OP_W(4), .DEST_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .io            (bus),
    .stall         (stall),
    .load_wait_in  (load_wait_in),
    .load_dest_in  (load_dest_in),
    .load_wait_out (load_wait_out),
    .load_dest_out (load_dest_out)
`ifdef VEX_PIPE_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_collide  (perf_collide)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          remain;
    logic [4:0]  dest;
    logic [1:0]  sew;
    logic [63:0] result;
  } pend_t;

  pend_t       pend[$];
  logic        expLw;
  logic [4:0]  expLd;
  int          nChecks;
  int          nFails;
  logic        lastReady;
  logic        lastWbValid;
  logic [63:0] lastWbResult;
  logic [4:0]  lastWbDest;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Element-wise reference: split into SEW-sized elements, apply the op with natural
  // wrap-around, keep SEW bits, substitute old elements where masked off, then repack.
  function automatic logic [63:0] refResult(input logic [3:0] op, input logic [1:0] sew,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] old, input logic masked,
                                            input logic [7:0] mask);
    int          ew;
    int          n;
    logic [63:0] res;
    logic [63:0] m;
    longint unsigned x;
    longint unsigned y;
    longint unsigned o;
    longint unsigned r;
    ew  = 8 << sew;
    n   = 64 / ew;
    m   = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
    res = '0;
    for (int i = 0; i < n; i++) begin
      x = (a >> (i * ew)) & m;
      y = (b >> (i * ew)) & m;
      o = (old >> (i * ew)) & m;
      case (op)
        4'd1:    r = x - y;
        4'd2:    r = x & y;
        4'd3:    r = x | y;
        4'd4:    r = x ^ y;
        4'd5:    r = x * y;
        default: r = x + y;
      endcase
      r = r & m;
      if (masked && !mask[i]) r = o;
      res = res | (r << (i * ew));
    end
    return res;
  endfunction

  // One clock cycle, entered at a negedge.
  // Drive inputs, check all outputs against the model, then advance the model across the posedge.
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [1:0] sew,
                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] old,
                               input logic masked, input logic [7:0] mask, input logic [4:0] dest,
                               input logic stl);
    logic        expReady;
    logic        acc;
    logic        lw;
    logic [4:0]  ld;
    int          idx;
    logic [63:0] res;
    lw = 1'($urandom_range(0, 1));
    ld = 5'($urandom_range(0, 31));
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_sew    = sew;
    bus.in_vs1    = a;
    bus.in_vs2    = b;
    bus.in_vd_old = old;
    bus.in_masked = masked;
    bus.in_mask   = mask;
    bus.in_dest   = dest;
    stall         = stl;
    load_wait_in  = lw;
    load_dest_in  = ld;
    #1;
    idx = -1;
    foreach (pend[k]) if (pend[k].remain == 0) idx = k;
    checkOutput("wb_valid", bus.wb_valid, (idx >= 0) && !stl);
    if (idx >= 0) begin
      checkOutput("wb_dest", bus.wb_dest, pend[idx].dest);
      checkOutput("wb_sew", bus.wb_sew, pend[idx].sew);
      checkOutput("wb_result", bus.wb_result, pend[idx].result);
    end
    // A non-MUL op would reach writeback together with any op due one edge from now.
    expReady = !stl;
    if (op != 4'd5) foreach (pend[k]) if (pend[k].remain == 1) expReady = 1'b0;
    checkOutput("in_ready", bus.in_ready, expReady);
    checkOutput("load_wait_out", load_wait_out, expLw);
    checkOutput("load_dest_out", load_dest_out, expLd);
    lastReady    = bus.in_ready;
    lastWbValid  = bus.wb_valid;
    lastWbResult = bus.wb_result;
    lastWbDest   = bus.wb_dest;
    acc = v && expReady;
    res = refResult(op, sew, a, b, old, masked, mask);
    @(posedge clk);
    expLw = lw;
    expLd = ld;
    if (!stl) begin
      for (int k = pend.size() - 1; k >= 0; k--) if (pend[k].remain == 0) pend.delete(k);
      foreach (pend[k]) pend[k].remain--;
      if (acc) pend.push_back(pend_t'{(op == 4'd5) ? L - 1 : 0, dest, sew, res});
    end
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic stl);
    applyStimulus(1'b0, 4'd0, 2'd0, 64'h0, 64'h0, 64'h0, 1'b0, 8'h0, 5'd0, stl);
  endtask

  task automatic drain();
    for (int i = 0; i < L + 1; i++) idleCycle(1'b0);
  endtask

  // Reset cycle with stall, in_valid and the side-band all active, since reset must override them.
  task automatic resetCycle();
    rst           = 1'b1;
    stall         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = 4'd0;
    load_wait_in  = 1'b1;
    load_dest_in  = 5'h1F;
    @(posedge clk);
    pend.delete();
    expLw = 1'b0;
    expLd = 5'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkResetState();
    bus.in_valid = 1'b0;
    stall        = 1'b0;
    #1;
    checkOutput("rst_wb_valid", bus.wb_valid, 1'b0);
    checkOutput("rst_wb_dest", bus.wb_dest, 5'd0);
    checkOutput("rst_wb_sew", bus.wb_sew, 2'd0);
    checkOutput("rst_wb_result", bus.wb_result, 64'h0);
    checkOutput("rst_load_wait", load_wait_out, 1'b0);
    checkOutput("rst_load_dest", load_dest_out, 5'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          pulses;
    int          pulseAt;
    logic [63:0] pulseRes;
    logic [3:0]  op;
    int          r;
    nChecks = 0;
    nFails  = 0;
    rst = 1'b1; stall = 1'b0; load_wait_in = 1'b0; load_dest_in = '0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_sew = '0; bus.in_vs1 = '0; bus.in_vs2 = '0;
    bus.in_vd_old = '0; bus.in_masked = 1'b0; bus.in_mask = '0; bus.in_dest = '0;
    expLw = 1'b0; expLd = '0;
    @(negedge clk);
    resetCycle();
    checkResetState();

    $display("[TB] ADD sew8 with no carry between bytes");
    applyStimulus(1'b1, 4'd0, 2'd0, 64'hFF, 64'h01, 64'h0, 1'b0, 8'h0, 5'd1, 1'b0);
    idleCycle(1'b0);
    checkOutput("add_nocarry_valid", lastWbValid, 1'b1);
    checkOutput("add_nocarry_result", lastWbResult, 64'h0);
    idleCycle(1'b0);
    checkOutput("add_single_pulse", lastWbValid, 1'b0);

    $display("[TB] MUL sew32 latency");
    applyStimulus(1'b1, 4'd5, 2'd2, 64'h00000003_00000002, 64'h00000007_00000005,
                  64'h0, 1'b0, 8'h0, 5'd2, 1'b0);
    idleCycle(1'b0);
    checkOutput("mul_t1_quiet", lastWbValid, 1'b0);
    idleCycle(1'b0);
    checkOutput("mul_t2_quiet", lastWbValid, 1'b0);
    idleCycle(1'b0);
    checkOutput("mul_t3_valid", lastWbValid, 1'b1);
    checkOutput("mul_t3_result", lastWbResult, 64'h00000015_0000000A);
    drain();

    $display("[TB] MUL/ADD writeback collision");
    applyStimulus(1'b1, 4'd5, 2'd3, 64'd6, 64'd7, 64'h0, 1'b0, 8'h0, 5'd3, 1'b0);
    idleCycle(1'b0);
    applyStimulus(1'b1, 4'd0, 2'd3, 64'd1, 64'd2, 64'h0, 1'b0, 8'h0, 5'd4, 1'b0);
    checkOutput("collide_ready_low", lastReady, 1'b0);
    applyStimulus(1'b1, 4'd0, 2'd3, 64'd1, 64'd2, 64'h0, 1'b0, 8'h0, 5'd4, 1'b0);
    checkOutput("collide_ready_high", lastReady, 1'b1);
    checkOutput("collide_mul_wb", lastWbValid, 1'b1);
    checkOutput("collide_mul_dest", lastWbDest, 5'd3);
    checkOutput("collide_mul_result", lastWbResult, 64'd42);
    idleCycle(1'b0);
    checkOutput("collide_add_wb", lastWbValid, 1'b1);
    checkOutput("collide_add_dest", lastWbDest, 5'd4);
    checkOutput("collide_add_result", lastWbResult, 64'd3);
    drain();

    $display("[TB] masked ADD sew32");
    applyStimulus(1'b1, 4'd0, 2'd2, 64'd1 | (64'd1 << 32), 64'd1 | (64'd1 << 32),
                  64'hDEADBEEF_00000000, 1'b1, 8'b01, 5'd5, 1'b0);
    idleCycle(1'b0);
    checkOutput("mask_result", lastWbResult, 64'hDEADBEEF_00000002);
    drain();

    $display("[TB] MUL held across a two-cycle stall");
    applyStimulus(1'b1, 4'd5, 2'd1, 64'h0004_0003_0002_0001, 64'h0009_0008_0007_0006,
                  64'h0, 1'b0, 8'h0, 5'd6, 1'b0);
    pulses = 0; pulseAt = 0; pulseRes = '0;
    for (int k = 1; k <= 6; k++) begin
      idleCycle(k <= 2);
      if (lastWbValid) begin
        pulses++;
        pulseAt  = k;
        pulseRes = lastWbResult;
      end
    end
    checkOutput("stall_pulse_count", pulses, 1);
    checkOutput("stall_pulse_cycle", pulseAt, 5);
    checkOutput("stall_pulse_result", pulseRes, 64'h0024_0018_000E_0006);
    drain();

    $display("[TB] reset drops an in-flight MUL");
    applyStimulus(1'b1, 4'd5, 2'd3, 64'd9, 64'd9, 64'h0, 1'b0, 8'h0, 5'd7, 1'b0);
    resetCycle();
    checkResetState();
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      idleCycle(1'b0);
      if (lastWbValid) pulses++;
    end
    checkOutput("rst_no_wb", pulses, 0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      op = 4'(r);
      else if (r < 8) op = 4'd5;
      else            op = 4'($urandom_range(6, 15));
      applyStimulus(1'($urandom_range(0, 9) < 7), op, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 99) < 15));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
